// File: rtl/muldiv_seq_pkg.sv
// Shared types and helpers for the iterative radix-2 multiply/divide sequencer.
package muldiv_seq_pkg;

  typedef enum logic [1:0] {
    MdMul  = 2'd0,
    MdImul = 2'd1,
    MdDiv  = 2'd2,
    MdIdiv = 2'd3
  } md_func_e;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StIter,
    StFix,
    StDone
  } md_state_e;

  localparam logic [3:0] WordLastCnt = 4'd15;
  localparam logic [3:0] ByteLastCnt = 4'd7;

  // Magnitude of an N-bit operand (N = 16 when word, else 8), zero-extended to 16 bits.
  function automatic logic [15:0] mag_n(input logic [15:0] v, input logic word,
                                        input logic neg);
    logic [7:0]  v_lo_neg;
    logic [15:0] v_n;
    v_lo_neg = 8'd0 - v[7:0];
    v_n      = word ? v : {8'd0, v[7:0]};
    if (!neg) return v_n;
    return word ? (16'd0 - v) : {8'd0, v_lo_neg};
  endfunction

endpackage

// File: rtl/muldiv_seq_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step on {acc,q}.
module muldiv_seq_step
  import muldiv_seq_pkg::*;
(
  input  logic        i_div,
  input  logic        i_word_op,
  input  logic [16:0] i_acc,
  input  logic [15:0] i_q,
  input  logic [15:0] i_opnd,
  output logic [16:0] o_acc,
  output logic [15:0] o_q
);

  logic [16:0] w_sum;
  logic [16:0] w_rem_sh;
  logic [15:0] w_quo_sh;
  logic [17:0] w_diff;

  always_comb begin
    w_sum    = i_q[0] ? (i_acc + {1'b0, i_opnd}) : i_acc;
    w_rem_sh = i_word_op ? {i_acc[15:0], i_q[15]} : {8'd0, i_acc[7:0], i_q[7]};
    w_quo_sh = i_word_op ? {i_q[14:0], 1'b0} : {8'd0, i_q[6:0], 1'b0};
    // Extra top bit of the trial difference acts as the borrow.
    w_diff   = {1'b0, w_rem_sh} - {2'b00, i_opnd};
    o_acc    = '0;
    o_q      = '0;
    if (i_div) begin
      if (!w_diff[17]) begin
        o_acc = w_diff[16:0];
        o_q   = w_quo_sh | 16'd1;
      end else begin
        o_acc = w_rem_sh;
        o_q   = w_quo_sh;
      end
    end else begin
      o_acc = {1'b0, w_sum[16:1]};
      o_q   = i_word_op ? {w_sum[0], i_q[15:1]} : {8'd0, w_sum[0], i_q[7:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer: FSM, iteration counter, sign bookkeeping and
// registered result/flag outputs for MUL, IMUL, DIV and IDIV.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter bit ZERO_EARLY = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [1:0]  i_func,
  input  logic        i_word_op,
  input  logic [31:0] i_x,
  input  logic [15:0] i_y,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_out,
  output logic        o_cfo,
  output logic        o_ofo,
  output logic        o_div_exc
);

  md_state_e   r_state;
  md_func_e    r_func;
  logic        r_word;
  logic [31:0] r_x;
  logic [15:0] r_y;
  logic [3:0]  r_cnt;
  logic [16:0] r_acc;
  logic [15:0] r_q;
  logic [15:0] r_opnd;
  logic        r_neg_res;
  logic        r_neg_rem;
  logic        r_chk_fail;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_out;
  logic        r_cfo;
  logic        r_div_exc;

  logic        w_is_div;
  logic        w_signed;
  logic        w_y_neg;
  logic [15:0] w_y_mag;
  logic        w_xm_neg;
  logic [15:0] w_xm_mag;
  logic        w_dv_neg;
  logic [31:0] w_dv_mag;
  logic [15:0] w_dv_hi;
  logic [15:0] w_dv_lo;
  logic        w_chk_fail;
  logic [31:0] w_prod;
  logic [31:0] w_prod_s;
  logic        w_mul_cf;
  logic [15:0] w_quo;
  logic [15:0] w_rem;
  logic [15:0] w_quo_s;
  logic [15:0] w_rem_s;
  logic [15:0] w_quo_lim;
  logic        w_exc;
  logic [31:0] w_fix_out;
  logic [16:0] w_step_acc;
  logic [15:0] w_step_q;

  // Operand preparation from the latched inputs.
  always_comb begin
    w_is_div   = r_func inside {MdDiv, MdIdiv};
    w_signed   = r_func inside {MdImul, MdIdiv};
    w_y_neg    = w_signed & (r_word ? r_y[15] : r_y[7]);
    w_y_mag    = mag_n(r_y, r_word, w_y_neg);
    w_xm_neg   = w_signed & (r_word ? r_x[15] : r_x[7]);
    w_xm_mag   = mag_n(r_x[15:0], r_word, w_xm_neg);
    w_dv_neg   = w_signed & (r_word ? r_x[31] : r_x[15]);
    w_dv_mag   = r_word ? r_x : {16'd0, r_x[15:0]};
    if (w_dv_neg) w_dv_mag = r_word ? (32'd0 - r_x) : {16'd0, 16'd0 - r_x[15:0]};
    w_dv_hi    = r_word ? w_dv_mag[31:16] : {8'd0, w_dv_mag[15:8]};
    w_dv_lo    = r_word ? w_dv_mag[15:0] : {8'd0, w_dv_mag[7:0]};
    w_chk_fail = w_is_div & ((w_y_mag == 16'd0) | (w_dv_hi >= w_y_mag));
  end

  // Sign fix-up and flag generation once the iterations are finished.
  always_comb begin
    w_prod   = r_word ? {r_acc[15:0], r_q} : {16'd0, r_acc[7:0], r_q[7:0]};
    w_prod_s = w_prod;
    if (r_neg_res) w_prod_s = r_word ? (32'd0 - w_prod) : {16'd0, 16'd0 - w_prod[15:0]};
    if (r_word) begin
      w_mul_cf = w_signed ? (w_prod_s[31:16] != {16{w_prod_s[15]}}) : (w_prod_s[31:16] != 16'd0);
    end else begin
      w_mul_cf = w_signed ? (w_prod_s[15:8] != {8{w_prod_s[7]}}) : (w_prod_s[15:8] != 8'd0);
    end
    w_quo     = r_word ? r_q : {8'd0, r_q[7:0]};
    w_rem     = r_word ? r_acc[15:0] : {8'd0, r_acc[7:0]};
    w_quo_lim = r_word ? (r_neg_res ? 16'h8000 : 16'h7fff) : (r_neg_res ? 16'h0080 : 16'h007f);
    w_exc     = w_is_div & (r_chk_fail | ((r_func == MdIdiv) & (w_quo > w_quo_lim)));
    w_quo_s   = r_neg_res ? (16'd0 - w_quo) : w_quo;
    w_rem_s   = r_neg_rem ? (16'd0 - w_rem) : w_rem;
    if (!w_is_div) begin
      w_fix_out = w_prod_s;
    end else if (w_exc) begin
      w_fix_out = '0;
    end else begin
      w_fix_out = r_word ? {w_rem_s, w_quo_s} : {16'd0, w_rem_s[7:0], w_quo_s[7:0]};
    end
  end

  muldiv_seq_step u_step (
    .i_div     (w_is_div),
    .i_word_op (r_word),
    .i_acc     (r_acc),
    .i_q       (r_q),
    .i_opnd    (r_opnd),
    .o_acc     (w_step_acc),
    .o_q       (w_step_q)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_func     <= MdMul;
      r_word     <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_q        <= '0;
      r_opnd     <= '0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_chk_fail <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_out      <= '0;
      r_cfo      <= 1'b0;
      r_div_exc  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_func  <= md_func_e'(i_func);
            r_word  <= i_word_op;
            r_x     <= i_x;
            r_y     <= i_y;
            r_busy  <= 1'b1;
            r_out   <= '0;
            r_cfo   <= 1'b0;
            r_state <= StPrep;
          end
        end
        StPrep: begin
          r_neg_rem  <= w_dv_neg;
          r_chk_fail <= w_chk_fail;
          r_cnt      <= r_word ? WordLastCnt : ByteLastCnt;
          if (w_is_div) begin
            r_acc     <= {1'b0, w_dv_hi};
            r_q       <= w_dv_lo;
            r_opnd    <= w_y_mag;
            r_neg_res <= w_dv_neg ^ w_y_neg;
          end else begin
            r_acc     <= '0;
            r_q       <= w_y_mag;
            r_opnd    <= w_xm_mag;
            r_neg_res <= w_xm_neg ^ w_y_neg;
          end
          if (ZERO_EARLY && w_chk_fail) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_div_exc <= 1'b1;
            r_out     <= '0;
            r_cfo     <= 1'b0;
            r_state   <= StDone;
          end else begin
            r_state <= StIter;
          end
        end
        StIter: begin
          r_acc <= w_step_acc;
          r_q   <= w_step_q;
          if (r_cnt == 4'd0) r_state <= StFix;
          else r_cnt <= r_cnt - 4'd1;
        end
        StFix: begin
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_out     <= w_fix_out;
          r_cfo     <= w_fix_cf_sel(w_is_div, w_mul_cf);
          r_div_exc <= w_exc;
          r_state   <= StDone;
        end
        StDone: begin
          r_done    <= 1'b0;
          r_div_exc <= 1'b0;
          r_state   <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Divides never report carry/overflow; those cases surface through div_exc instead.
  function automatic logic w_fix_cf_sel(input logic is_div, input logic mul_cf);
    return !is_div & mul_cf;
  endfunction

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_out     = r_out;
  assign o_cfo     = r_cfo;
  assign o_ofo     = r_cfo;
  assign o_div_exc = r_div_exc;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: integer-arithmetic reference model, per-cycle monitor,
// directed corner cases and randomized operations.
module tb_muldiv_seq;

  localparam bit ZE = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  func;
  logic        word_op;
  logic [31:0] x;
  logic [15:0] y;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic        cfo;
  logic        ofo;
  logic        div_exc;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Currently tracked operation (expected timing and results).
  bit          act_valid = 1'b0;
  int          act_s;
  int          act_lat;
  logic [31:0] act_out;
  bit          act_cf;
  bit          act_exc;

  bit          mon_en = 1'b0;
  int          done_cnt = 0;
  logic [31:0] cap_out;
  bit          cap_cf;
  bit          cap_exc;
  int          cap_cyc;

  muldiv_seq #(.ZERO_EARLY(ZE)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_func    (func),
    .i_word_op (word_op),
    .i_x       (x),
    .i_y       (y),
    .o_busy    (busy),
    .o_done    (done),
    .o_out     (out),
    .o_cfo     (cfo),
    .o_ofo     (ofo),
    .o_div_exc (div_exc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint sx(input longint v, input int bits);
    longint m = longint'(1) << bits;
    longint r = v & (m - 1);
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  // Reference: plain integer arithmetic on the architectural operand widths.
  function automatic void model(input logic [1:0] f, input bit w, input logic [31:0] xv,
                                input logic [15:0] yv, output logic [31:0] o, output bit cf,
                                output bit exc, output int lat);
    int     n = w ? 16 : 8;
    longint m = longint'(1) << n;
    longint xu = longint'(xv);
    longint yu = longint'(yv);
    longint a, b, p, dv, d, q, r, adv, ad;
    bit     early = 1'b0;
    o = '0; cf = 1'b0; exc = 1'b0; lat = n + 3;
    case (f)
      2'd0: begin
        a = xu & (m - 1); b = yu & (m - 1); p = a * b;
        cf = (p >> n) != 0;
        o = 32'(p);
      end
      2'd1: begin
        a = sx(xu, n); b = sx(yu, n); p = a * b;
        cf = (p < -(m / 2)) || (p > m / 2 - 1);
        o = 32'(p & (m * m - 1));
      end
      default: begin
        dv = (f == 2'd3) ? sx(xu, 2 * n) : (xu & (m * m - 1));
        d  = (f == 2'd3) ? sx(yu, n) : (yu & (m - 1));
        if (d == 0) begin
          early = 1'b1;
          exc   = 1'b1;
        end else begin
          adv   = (dv < 0) ? -dv : dv;
          ad    = (d < 0) ? -d : d;
          early = adv >= ad * m;
          q = dv / d;
          r = dv % d;
          exc = early || (q > m / 2 - 1 && f == 2'd3) || (q < -(m / 2)) || (q >= m);
          if (!exc) o = 32'(((r & (m - 1)) << n) | (q & (m - 1)));
        end
        if (early && ZE) lat = 2;
      end
    endcase
  endfunction

  // Per-cycle comparison against the tracked operation.
  always @(negedge clk) begin
    bit eb, ed;
    if (mon_en) begin
      eb = act_valid && cyc > act_s && cyc < act_s + act_lat;
      ed = act_valid && cyc == act_s + act_lat;
      check("busy", 32'(busy), 32'(eb));
      check("done", 32'(done), 32'(ed));
      check("div_exc", 32'(div_exc), 32'(ed && act_exc));
      if (done === 1'b1) begin
        done_cnt++;
        cap_out = out; cap_cf = cfo; cap_exc = div_exc; cap_cyc = cyc;
      end
      if (ed) begin
        check("out", out, act_out);
        check("cfo", 32'(cfo), 32'(act_cf));
        check("ofo", 32'(ofo), 32'(act_cf));
      end else if (!act_valid) begin
        check("idle out", out, 32'd0);
        check("idle cfo", 32'(cfo), 32'd0);
        check("idle ofo", 32'(ofo), 32'd0);
      end else if (cyc > act_s + act_lat) begin
        check("hold out", out, act_out);
        check("hold cfo", 32'(cfo), 32'(act_cf));
      end
    end
  end

  task automatic step_cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one op in the current cycle; returns in the cycle after done (IDLE again).
  task automatic do_op(input logic [1:0] f, input bit w, input logic [31:0] xv,
                       input logic [15:0] yv, input bit junk, output int s);
    logic [31:0] eo;
    bit          ec, ee;
    int          lat;
    model(f, w, xv, yv, eo, ec, ee, lat);
    cap_cyc = -1;
    cap_out = 32'hdeadbeef;
    func = f; word_op = w; x = xv; y = yv; start = 1'b1;
    act_valid = 1'b1; act_s = cyc; act_lat = lat; act_out = eo; act_cf = ec; act_exc = ee;
    s = cyc;
    for (int i = 1; i <= lat; i++) begin
      step_cyc();
      if (junk) begin
        start = 1'b1; func = 2'($urandom); word_op = 1'($urandom);
        x = $urandom; y = 16'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    step_cyc();
    start = 1'b0;
  endtask

  initial begin
    int          s, d0, gap;
    logic [31:0] eo, xv;
    logic [15:0] yv;
    bit          ec, ee;
    int          lat;
    rst = 1'b1; start = 1'b0; func = 2'd0; word_op = 1'b0; x = '0; y = '0;
    repeat (3) step_cyc();
    rst = 1'b0;
    mon_en = 1'b1;
    step_cyc();

    // Pin the model itself with hand-computed values.
    model(2'd0, 1'b1, 32'h1234, 16'h5678, eo, ec, ee, lat);
    check("model mul out", eo, 32'h06260060);
    check("model mul lat", 32'(lat), 32'd19);
    model(2'd1, 1'b0, 32'h00ff, 16'h0002, eo, ec, ee, lat);
    check("model imul out", eo, 32'h0000fffe);
    model(2'd3, 1'b1, 32'hfffffff9, 16'h0002, eo, ec, ee, lat);
    check("model idiv out", eo, 32'hfffffffd);

    do_op(2'd0, 1'b1, 32'h1234, 16'h5678, 1'b0, s);
    check("t1 out", cap_out, 32'h06260060);
    check("t1 cf", 32'(cap_cf), 32'd1);
    check("t1 lat", 32'(cap_cyc - s), 32'd19);

    do_op(2'd1, 1'b0, 32'h00ff, 16'h0002, 1'b0, s);
    check("t2 out", cap_out, 32'h0000fffe);
    check("t2 cf", 32'(cap_cf), 32'd0);
    check("t2 lat", 32'(cap_cyc - s), 32'd11);

    do_op(2'd2, 1'b1, 32'h00010005, 16'h0002, 1'b0, s);
    check("t3 div out", cap_out, 32'h00018002);
    check("t3 div exc", 32'(cap_exc), 32'd0);
    do_op(2'd3, 1'b1, 32'hfffffff9, 16'h0002, 1'b0, s);
    check("t3 idiv out", cap_out, 32'hfffffffd);

    do_op(2'd2, 1'b1, 32'h00001234, 16'h0000, 1'b0, s);
    check("t4 div0 lat", 32'(cap_cyc - s), 32'd2);
    check("t4 div0 exc", 32'(cap_exc), 32'd1);
    check("t4 div0 out", cap_out, 32'd0);
    do_op(2'd3, 1'b0, 32'h00008000, 16'h00ff, 1'b0, s);
    check("t4 idiv early lat", 32'(cap_cyc - s), 32'd2);
    check("t4 idiv early exc", 32'(cap_exc), 32'd1);
    do_op(2'd3, 1'b0, 32'h00000080, 16'h0001, 1'b0, s);
    check("t4 idiv ovf lat", 32'(cap_cyc - s), 32'd11);
    check("t4 idiv ovf exc", 32'(cap_exc), 32'd1);
    do_op(2'd3, 1'b0, 32'h0000ff80, 16'h0001, 1'b0, s);
    check("t4 idiv -128", cap_out, 32'h00000080);
    do_op(2'd3, 1'b0, 32'h00000080, 16'h00ff, 1'b0, s);
    check("t4 idiv 128/-1", cap_out, 32'h00000080);

    d0 = done_cnt;
    do_op(2'd0, 1'b1, 32'h0000beef, 16'h1357, 1'b1, s);
    check("t5 one done", 32'(done_cnt - d0), 32'd1);
    check("t5 out", cap_out, 32'(32'hbeef * 32'h1357));

    // Reset in the middle of a word divide.
    model(2'd2, 1'b1, 32'h00123456, 16'h0100, eo, ec, ee, lat);
    func = 2'd2; word_op = 1'b1; x = 32'h00123456; y = 16'h0100; start = 1'b1;
    act_valid = 1'b1; act_s = cyc; act_lat = lat; act_out = eo; act_cf = ec; act_exc = ee;
    s = cyc; d0 = done_cnt;
    step_cyc();
    start = 1'b0;
    repeat (4) step_cyc();
    rst = 1'b1;
    step_cyc();
    rst = 1'b0;
    act_valid = 1'b0;
    check("t6 busy", 32'(busy), 32'd0);
    check("t6 out", out, 32'd0);
    step_cyc();
    check("t6 no done", 32'(done_cnt - d0), 32'd0);
    do_op(2'd2, 1'b1, 32'h00123456, 16'h0100, 1'b0, s);
    check("t6 restart out", cap_out, 32'h00561234);
    check("t6 restart lat", 32'(cap_cyc - s), 32'd19);

    for (int k = 0; k < 250; k++) begin
      xv = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) xv = 32'd0 - xv;
      case ($urandom_range(0, 3))
        0: yv = 16'($urandom_range(0, 2));
        1: yv = 16'($urandom >> $urandom_range(0, 15));
        2: yv = 16'd0 - 16'($urandom_range(1, 3));
        default: yv = 16'($urandom);
      endcase
      gap = $urandom_range(0, 2);
      repeat (gap) step_cyc();
      do_op(2'($urandom), 1'($urandom), xv, yv, ($urandom_range(0, 3) == 0), s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
